dbg_arb: RTL and testbench

Two-requester arbiter for the shared debug bus (`dbg_addr`/`dbg_wen`/`dbg_ren`/`dbg_wdata` → `dbg_rdata`/`dbg_rdata_vld`). It sits between the debug segment decoder and its masters (host MMIO bridge on port 0, program loader/stepper on port 1). It serialises single-beat transactions with round-robin fairness. During a read it holds `dbg_addr` stable until the read data returns, because the return-data steering downstream is keyed on the current segment. It also recovers from a missing read response with a timeout.

---
 rtl/dbg.sv | 14 +
 rtl/mcs4.sv | 4 +
 rtl/dbg_arb.sv | 152 +++++++++++++++
 tb/tb_dbg_arb.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dbg.sv
// rtl/dbg.sv - debug bus address types
package dbg;
    typedef enum logic [1:0] {
        SEG_ROM = 2'd0,
        SEG_RAM = 2'd1,
        SEG_IO  = 2'd2,
        SEG_CTL = 2'd3
    } seg_t;

    typedef struct packed {
        seg_t       seg;
        logic [7:0] off;
    } addr_t;
endpackage

// File: rtl/mcs4.sv
// rtl/mcs4.sv - basic data types shared with the MCS-4 core
package mcs4;
    typedef logic [7:0] byte_t;
endpackage

// File: rtl/dbg_arb.sv
// rtl/dbg_arb.sv - round-robin two-port arbiter for the shared debug bus
module dbg_arb #(
    parameter int Timeout_cycles = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_req,
    input  logic        m0_wr,
    input  dbg::addr_t  m0_addr,
    input  mcs4::byte_t m0_wdata,
    output logic        m0_gnt,
    output mcs4::byte_t m0_rdata,
    output logic        m0_rdata_vld,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic        m1_wr,
    input  dbg::addr_t  m1_addr,
    input  mcs4::byte_t m1_wdata,
    output logic        m1_gnt,
    output mcs4::byte_t m1_rdata,
    output logic        m1_rdata_vld,
    output logic        m1_err,
    output dbg::addr_t  dbg_addr,
    output logic        dbg_wen,
    output logic        dbg_ren,
    output mcs4::byte_t dbg_wdata,
    input  mcs4::byte_t dbg_rdata,
    input  logic        dbg_rdata_vld,
    output logic        busy
);
    localparam int CntW = $clog2(Timeout_cycles + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RD = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            owner_q, owner_d;
    logic            last_q, last_d;
    logic            wr_q, wr_d;
    dbg::addr_t      addr_q, addr_d;
    mcs4::byte_t     wdata_q, wdata_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    mcs4::byte_t     rdata0_q, rdata0_d;
    mcs4::byte_t     rdata1_q, rdata1_d;
    logic            rsp_vld_q, rsp_vld_d;
    logic            rsp_err_q, rsp_err_d;

    logic any_req;
    logic winner;
    logic timeout_hit;

    // On a tie the port that did not win last time goes first.
    assign any_req     = m0_req | m1_req;
    assign winner      = (m0_req & m1_req) ? ~last_q : m1_req;
    assign timeout_hit = (cnt_q == CntW'(Timeout_cycles));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            owner_q   <= 1'b0;
            last_q    <= 1'b1;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            cnt_q     <= '0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
            rsp_vld_q <= 1'b0;
            rsp_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            cnt_q     <= cnt_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
            rsp_vld_q <= rsp_vld_d;
            rsp_err_q <= rsp_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = ISSUE;
            ISSUE:   state_d = wr_q ? IDLE : WAIT_RD;
            WAIT_RD: if (dbg_rdata_vld || timeout_hit) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        owner_d   = owner_q;
        last_d    = last_q;
        wr_d      = wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;
        rsp_vld_d = 1'b0;
        rsp_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    owner_d = winner;
                    last_d  = winner;
                    wr_d    = winner ? m1_wr    : m0_wr;
                    addr_d  = winner ? m1_addr  : m0_addr;
                    wdata_d = winner ? m1_wdata : m0_wdata;
                end
            end
            ISSUE: begin
                cnt_d = CntW'(1);
            end
            WAIT_RD: begin
                // A response arriving on the timeout cycle still counts as good data.
                if (dbg_rdata_vld || timeout_hit) begin
                    rsp_vld_d = 1'b1;
                    rsp_err_d = ~dbg_rdata_vld;
                    if (owner_q) rdata1_d = dbg_rdata_vld ? dbg_rdata : 8'hEE;
                    else         rdata0_d = dbg_rdata_vld ? dbg_rdata : 8'hEE;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        busy         = (state_q != IDLE);
        dbg_addr     = addr_q;
        dbg_wdata    = wdata_q;
        dbg_wen      = (state_q == ISSUE) &  wr_q;
        dbg_ren      = (state_q == ISSUE) & ~wr_q;
        m0_gnt       = (state_q == ISSUE) & ~owner_q;
        m1_gnt       = (state_q == ISSUE) &  owner_q;
        m0_rdata     = rdata0_q;
        m1_rdata     = rdata1_q;
        m0_rdata_vld = rsp_vld_q & ~owner_q;
        m1_rdata_vld = rsp_vld_q &  owner_q;
        m0_err       = rsp_err_q & ~owner_q;
        m1_err       = rsp_err_q &  owner_q;
    end
endmodule

// File: tb/tb_dbg_arb.sv
// tb/tb_dbg_arb.sv - self-checking bench for dbg_arb
module tb_dbg_arb;
    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_req, m0_wr, m0_gnt, m0_rdata_vld, m0_err;
    dbg::addr_t  m0_addr;
    mcs4::byte_t m0_wdata, m0_rdata;
    logic        m1_req, m1_wr, m1_gnt, m1_rdata_vld, m1_err;
    dbg::addr_t  m1_addr;
    mcs4::byte_t m1_wdata, m1_rdata;
    dbg::addr_t  dbg_addr;
    logic        dbg_wen, dbg_ren, dbg_rdata_vld, busy;
    mcs4::byte_t dbg_wdata, dbg_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    logic [42:0] all_outs;
    assign all_outs = {m0_gnt, m0_rdata, m0_rdata_vld, m0_err,
                       m1_gnt, m1_rdata, m1_rdata_vld, m1_err,
                       dbg_addr, dbg_wen, dbg_ren, dbg_wdata, busy};

    always #5 clk = ~clk;

    dbg_arb #(.Timeout_cycles(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rdata(m0_rdata), .m0_rdata_vld(m0_rdata_vld), .m0_err(m0_err),
        .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rdata(m1_rdata), .m1_rdata_vld(m1_rdata_vld), .m1_err(m1_err),
        .dbg_addr(dbg_addr), .dbg_wen(dbg_wen), .dbg_ren(dbg_ren), .dbg_wdata(dbg_wdata),
        .dbg_rdata(dbg_rdata), .dbg_rdata_vld(dbg_rdata_vld), .busy(busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        m0_req = 1'b0; m0_wr = 1'b0; m0_addr = '0; m0_wdata = '0;
        m1_req = 1'b0; m1_wr = 1'b0; m1_addr = '0; m1_wdata = '0;
        dbg_rdata = '0; dbg_rdata_vld = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic set_req(input int p, input logic wr, input dbg::addr_t a, input mcs4::byte_t d);
        if (p == 0) begin
            m0_req = 1'b1; m0_wr = wr; m0_addr = a; m0_wdata = d;
        end else begin
            m1_req = 1'b1; m1_wr = wr; m1_addr = a; m1_wdata = d;
        end
    endtask

    task automatic clr_req(input int p);
        if (p == 0) m0_req = 1'b0;
        else        m1_req = 1'b0;
    endtask

    task automatic wait_gnt(output int lat, output int who);
        lat = 0;
        who = -1;
        while (!(m0_gnt || m1_gnt) && lat < 30) begin
            tick();
            lat++;
        end
        if (m0_gnt && m1_gnt) who = 2;
        else if (m0_gnt)      who = 0;
        else if (m1_gnt)      who = 1;
    endtask

    // Called on the grant cycle of a read; returns the observed response.
    task automatic read_resp(input int p, input int lat_l, input mcs4::byte_t d,
                             output int when, output mcs4::byte_t got, output logic e,
                             output int pulses, output logic stable);
        dbg::addr_t a0;
        a0 = dbg_addr;
        when = -1; got = '0; e = 1'b0; pulses = 0; stable = 1'b1;
        for (int k = 1; k <= TO + 6; k++) begin
            dbg_rdata_vld = (k - 1 == lat_l);
            dbg_rdata     = d;
            tick();
            if (when < 0 && (dbg_addr !== a0 || dbg_wen !== 1'b0 || dbg_ren !== 1'b0)) stable = 1'b0;
            pulses += int'(m0_rdata_vld) + int'(m1_rdata_vld);
            if (when < 0 && ((p == 0) ? m0_rdata_vld : m1_rdata_vld) === 1'b1) begin
                when = k;
                got  = (p == 0) ? m0_rdata : m1_rdata;
                e    = (p == 0) ? m0_err   : m1_err;
            end
        end
        dbg_rdata_vld = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if (all_outs !== 43'd0) begin
            n_fail++; $display("FAIL reset_outputs: got %h want 0", all_outs);
        end
    endtask

    task automatic test_single_write();
        int lat, who, wen_cnt, other_cnt;
        dbg::addr_t a;
        do_reset();
        a.seg = dbg::SEG_CTL; a.off = 8'h00;
        set_req(0, 1'b1, a, 8'h07);
        wait_gnt(lat, who);
        n_tests++;
        if (who !== 0 || lat !== 1) begin
            n_fail++; $display("FAIL write_gnt: got who=%0d lat=%0d want who=0 lat=1", who, lat);
        end
        n_tests++;
        if (dbg_wen !== 1'b1 || dbg_ren !== 1'b0 || dbg_addr !== a || dbg_wdata !== 8'h07) begin
            n_fail++; $display("FAIL write_bus: got wen=%b ren=%b addr=%h wdata=%h want 1 0 %h 07",
                               dbg_wen, dbg_ren, dbg_addr, dbg_wdata, a);
        end
        clr_req(0);
        wen_cnt = 0; other_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            wen_cnt   += int'(dbg_wen);
            other_cnt += int'(m0_rdata_vld) + int'(m1_rdata_vld) + int'(m0_gnt) + int'(m1_gnt);
        end
        n_tests++;
        if (wen_cnt !== 0 || other_cnt !== 0) begin
            n_fail++; $display("FAIL write_one_pulse: got extra wen=%0d other=%0d want 0 0", wen_cnt, other_cnt);
        end
        n_tests++;
        if (dbg_addr !== a || dbg_wdata !== 8'h07 || busy !== 1'b0) begin
            n_fail++; $display("FAIL write_hold: got addr=%h wdata=%h busy=%b want %h 07 0",
                               dbg_addr, dbg_wdata, busy, a);
        end
    endtask

    task automatic test_read_latency();
        int lat, who, when, pulses;
        mcs4::byte_t got;
        logic e, stable;
        dbg::addr_t a;
        do_reset();
        a.seg = dbg::SEG_ROM; a.off = 8'h10;
        set_req(1, 1'b0, a, 8'h00);
        wait_gnt(lat, who);
        n_tests++;
        if (who !== 1 || lat !== 1 || dbg_ren !== 1'b1 || dbg_wen !== 1'b0 || dbg_addr !== a) begin
            n_fail++; $display("FAIL read_issue: got who=%0d lat=%0d ren=%b wen=%b addr=%h want 1 1 1 0 %h",
                               who, lat, dbg_ren, dbg_wen, dbg_addr, a);
        end
        clr_req(1);
        read_resp(1, 2, 8'h5A, when, got, e, pulses, stable);
        n_tests++;
        if (when !== 3 || got !== 8'h5A || e !== 1'b0 || pulses !== 1 || stable !== 1'b1) begin
            n_fail++; $display("FAIL read_lat2: got when=%0d data=%h err=%b pulses=%0d stable=%b want 3 5a 0 1 1",
                               when, got, e, pulses, stable);
        end
    endtask

    task automatic test_simultaneous();
        int rem[2];
        mcs4::byte_t cur[2];
        int last, exp_who, who, prev_g, ngnt;
        dbg::addr_t a;
        do_reset();
        rem = '{4, 4};
        cur = '{8'h10, 8'h20};
        last = 1; prev_g = -1; ngnt = 0;
        a.seg = dbg::SEG_RAM; a.off = 8'h40;
        set_req(0, 1'b1, a, cur[0]);
        a.off = 8'h41;
        set_req(1, 1'b1, a, cur[1]);
        for (int c = 1; c <= 40 && (rem[0] > 0 || rem[1] > 0); c++) begin
            tick();
            if (m0_gnt || m1_gnt) begin
                who = (m0_gnt && m1_gnt) ? 2 : (m1_gnt ? 1 : 0);
                exp_who = (rem[0] > 0 && rem[1] > 0) ? 1 - last : (rem[0] > 0 ? 0 : 1);
                n_tests++;
                if (who !== exp_who) begin
                    n_fail++; $display("FAIL rr_order[%0d]: got port %0d want %0d", ngnt, who, exp_who);
                end
                if (prev_g >= 0) begin
                    n_tests++;
                    if (c - prev_g !== 2) begin
                        n_fail++; $display("FAIL rr_spacing[%0d]: got %0d cycles want 2", ngnt, c - prev_g);
                    end
                end
                n_tests++;
                if (dbg_wdata !== cur[exp_who]) begin
                    n_fail++; $display("FAIL rr_wdata[%0d]: got %h want %h", ngnt, dbg_wdata, cur[exp_who]);
                end
                prev_g = c; last = exp_who; ngnt++;
                rem[exp_who]--;
                if (rem[exp_who] == 0) begin
                    clr_req(exp_who);
                end else begin
                    cur[exp_who] = cur[exp_who] + 8'h01;
                    if (exp_who == 0) m0_wdata = cur[0];
                    else              m1_wdata = cur[1];
                end
            end
        end
        n_tests++;
        if (ngnt !== 8) begin
            n_fail++; $display("FAIL rr_count: got %0d grants want 8", ngnt);
        end
    endtask

    task automatic test_timeout();
        int lat, who, when, pulses;
        mcs4::byte_t got;
        logic e, stable;
        dbg::addr_t a;
        do_reset();
        a.seg = dbg::SEG_IO; a.off = 8'h05;
        set_req(0, 1'b0, a, 8'h00);
        wait_gnt(lat, who);
        n_tests++;
        if (who !== 0 || dbg_ren !== 1'b1) begin
            n_fail++; $display("FAIL timeout_issue: got who=%0d ren=%b want 0 1", who, dbg_ren);
        end
        clr_req(0);
        read_resp(0, TO + 3, 8'h99, when, got, e, pulses, stable);
        n_tests++;
        if (when !== TO + 1 || got !== 8'hEE || e !== 1'b1 || pulses !== 1 || stable !== 1'b1) begin
            n_fail++; $display("FAIL timeout_rsp: got when=%0d data=%h err=%b pulses=%0d stable=%b want %0d ee 1 1 1",
                               when, got, e, pulses, stable, TO + 1);
        end
        n_tests++;
        if (m0_rdata !== 8'hEE || busy !== 1'b0) begin
            n_fail++; $display("FAIL timeout_late_vld: got rdata=%h busy=%b want ee 0", m0_rdata, busy);
        end
    endtask

    task automatic test_coincident();
        int lat, who, when, pulses;
        mcs4::byte_t got;
        logic e, stable;
        dbg::addr_t a;
        a.seg = dbg::SEG_RAM; a.off = 8'h77;
        set_req(1, 1'b0, a, 8'h00);
        wait_gnt(lat, who);
        clr_req(1);
        read_resp(1, TO, 8'h33, when, got, e, pulses, stable);
        n_tests++;
        if (who !== 1 || when !== TO + 1 || got !== 8'h33 || e !== 1'b0 || pulses !== 1) begin
            n_fail++; $display("FAIL coincident: got who=%0d when=%0d data=%h err=%b pulses=%0d want 1 %0d 33 0 1",
                               who, when, got, e, pulses, TO + 1);
        end
    endtask

    task automatic test_reset_mid_read();
        int lat, who, pulses;
        dbg::addr_t a;
        do_reset();
        a.seg = dbg::SEG_ROM; a.off = 8'h3C;
        set_req(0, 1'b0, a, 8'h00);
        wait_gnt(lat, who);
        clr_req(0);
        tick(); tick(); tick();
        dbg_rdata = 8'h42;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (all_outs !== 43'd0) begin
            n_fail++; $display("FAIL midreset_async: got %h want 0", all_outs);
        end
        dbg_rdata_vld = 1'b1;
        tick(); tick();
        rst_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (k == 2) dbg_rdata_vld = 1'b0;
            pulses += int'(m0_rdata_vld) + int'(m1_rdata_vld) + int'(busy);
        end
        n_tests++;
        if (pulses !== 0) begin
            n_fail++; $display("FAIL midreset_no_vld: got %0d pulses want 0", pulses);
        end
        set_req(0, 1'b1, a, 8'h01);
        set_req(1, 1'b1, a, 8'h02);
        wait_gnt(lat, who);
        clr_req(0);
        clr_req(1);
        tick();
        n_tests++;
        if (who !== 0) begin
            n_fail++; $display("FAIL midreset_tie: got port %0d want 0", who);
        end
    endtask

    task automatic test_random();
        int mask, exp_who, last, lat, who, lat_l, exp_when, when, pulses;
        logic wr_a[2];
        dbg::addr_t ad[2];
        mcs4::byte_t da[2];
        mcs4::byte_t d, got;
        logic e, stable;
        do_reset();
        last = 1;
        for (int it = 0; it < 40; it++) begin
            mask = int'($urandom_range(1, 3));
            for (int p = 0; p < 2; p++) begin
                wr_a[p] = 1'($urandom);
                ad[p]   = dbg::addr_t'(10'($urandom));
                da[p]   = 8'($urandom);
                if (((mask >> p) & 1) == 1) set_req(p, wr_a[p], ad[p], da[p]);
            end
            exp_who = (mask == 3) ? 1 - last : (mask == 1 ? 0 : 1);
            wait_gnt(lat, who);
            n_tests++;
            if (who !== exp_who || lat !== 1) begin
                n_fail++; $display("FAIL rand_gnt[%0d]: got port %0d lat %0d want %0d 1", it, who, lat, exp_who);
            end
            n_tests++;
            if (dbg_addr !== ad[exp_who] || dbg_wdata !== da[exp_who] ||
                dbg_wen !== wr_a[exp_who] || dbg_ren !== !wr_a[exp_who]) begin
                n_fail++; $display("FAIL rand_bus[%0d]: got addr=%h wdata=%h wen=%b ren=%b want %h %h %b %b",
                                   it, dbg_addr, dbg_wdata, dbg_wen, dbg_ren,
                                   ad[exp_who], da[exp_who], wr_a[exp_who], !wr_a[exp_who]);
            end
            clr_req(0);
            clr_req(1);
            last = exp_who;
            if (!wr_a[exp_who]) begin
                lat_l    = int'($urandom_range(1, TO + 3));
                d        = 8'($urandom);
                exp_when = (lat_l <= TO) ? lat_l + 1 : TO + 1;
                read_resp(exp_who, lat_l, d, when, got, e, pulses, stable);
                n_tests++;
                if (when !== exp_when || got !== ((lat_l <= TO) ? d : 8'hEE) ||
                    e !== (lat_l > TO) || pulses !== 1 || stable !== 1'b1) begin
                    n_fail++; $display("FAIL rand_rsp[%0d]: L=%0d got when=%0d data=%h err=%b pulses=%0d stable=%b want %0d %h %b 1 1",
                                       it, lat_l, when, got, e, pulses, stable, exp_when,
                                       (lat_l <= TO) ? d : 8'hEE, lat_l > TO);
                end
            end else begin
                tick();
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_read_latency();
        test_simultaneous();
        test_timeout();
        test_coincident();
        test_reset_mid_read();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
